// File: rtl/data_memory_ctrl.sv
// Byte-addressed data memory controller with fixed request-to-response latency.
// It handles one request at a time, supports byte, half-word and word accesses,
// and rejects misaligned or out-of-range requests.
module data_memory_ctrl #(
  parameter int unsigned DEPTH_BYTES = 1024,
  parameter int unsigned LATENCY     = 2
) (
  input  logic        clk_i,
  input  logic        rst_i,
  input  logic        req_i,
  input  logic        we_i,
  input  logic [1:0]  size_i,
  input  logic        sign_i,
  input  logic [31:0] addr_i,
  input  logic [31:0] wdata_i,
  output logic        ready_o,
  output logic        rvalid_o,
  output logic        done_o,
  output logic        err_o,
  output logic [31:0] rdata_o
);

  localparam int unsigned AW = $clog2(DEPTH_BYTES);
  localparam int unsigned CW = (LATENCY > 2) ? $clog2(LATENCY) : 1;
  localparam logic [CW-1:0] CNT_LOAD = CW'((LATENCY > 1) ? (LATENCY - 2) : 0);

  typedef enum logic [1:0] {IDLE, WAIT, RESP} state_t;

  state_t        state_q, state_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic          we_q, we_d;
  logic [1:0]    size_q, size_d;
  logic          sign_q, sign_d;
  logic [AW-1:0] addr_q, addr_d;
  logic [31:0]   wdata_q, wdata_d;
  logic          bad_q, bad_d;
  logic          rvalid_q, rvalid_d;
  logic          done_q, done_d;
  logic          err_q, err_d;
  logic [31:0]   rdata_q, rdata_d;
  logic          mem_we;
  logic [7:0]    rb [4];
  logic [31:0]   raw;

  logic [7:0] mem [DEPTH_BYTES];

  function automatic logic [2:0] size_bytes(input logic [1:0] s);
    case (s)
      2'b00:   return 3'd1;
      2'b01:   return 3'd2;
      default: return 3'd4;
    endcase
  endfunction

  // Illegal size, misalignment, or any byte past the end (no address wrap).
  function automatic logic req_bad(input logic [1:0] s, input logic [31:0] a);
    logic [32:0] last_b;
    if (s == 2'b11) return 1'b1;
    if (s == 2'b01 && a[0]) return 1'b1;
    if (s == 2'b10 && a[1:0] != 2'b00) return 1'b1;
    last_b = {1'b0, a} + 33'(size_bytes(s)) - 33'd1;
    return last_b >= 33'(DEPTH_BYTES);
  endfunction

  assign ready_o  = (state_q == IDLE) && !rst_i;
  assign rvalid_o = rvalid_q;
  assign done_o   = done_q;
  assign err_o    = err_q;
  assign rdata_o  = rdata_q;

  // Next-state, request capture and response generation for the RESP cycle.
  always_comb begin
    state_d  = state_q;
    cnt_d    = cnt_q;
    we_d     = we_q;
    size_d   = size_q;
    sign_d   = sign_q;
    addr_d   = addr_q;
    wdata_d  = wdata_q;
    bad_d    = bad_q;
    rvalid_d = 1'b0;
    done_d   = 1'b0;
    err_d    = 1'b0;
    rdata_d  = 32'd0;
    mem_we   = 1'b0;
    raw      = 32'd0;
    for (int k = 0; k < 4; k++) rb[k] = 8'd0;

    case (state_q)
      IDLE: begin
        if (req_i) begin
          we_d    = we_i;
          size_d  = size_i;
          sign_d  = sign_i;
          addr_d  = addr_i[AW-1:0];
          wdata_d = wdata_i;
          bad_d   = req_bad(size_i, addr_i);
          cnt_d   = CNT_LOAD;
          state_d = (LATENCY > 1) ? WAIT : RESP;
        end
      end
      WAIT: begin
        if (cnt_q == '0) state_d = RESP;
        else             cnt_d   = cnt_q - CW'(1);
      end
      RESP: begin
        state_d = IDLE;
        mem_we  = we_q && !bad_q;
      end
      default: state_d = IDLE;
    endcase

    // Outputs are registered, so the pulse is prepared on the edge entering RESP.
    if (state_d == RESP) begin
      if (bad_d)     err_d  = 1'b1;
      else if (we_d) done_d = 1'b1;
      else begin
        rvalid_d = 1'b1;
        for (int k = 0; k < 4; k++) rb[k] = mem[addr_d + AW'(k)];
        raw = {rb[3], rb[2], rb[1], rb[0]};
        case (size_d)
          2'b00:   rdata_d = sign_d ? {{24{raw[7]}}, raw[7:0]}   : {24'd0, raw[7:0]};
          2'b01:   rdata_d = sign_d ? {{16{raw[15]}}, raw[15:0]} : {16'd0, raw[15:0]};
          default: rdata_d = raw;
        endcase
      end
    end
  end

  // Control and request registers; reset drops any in-flight request.
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      state_q  <= IDLE;
      cnt_q    <= '0;
      we_q     <= 1'b0;
      size_q   <= 2'b00;
      sign_q   <= 1'b0;
      addr_q   <= '0;
      wdata_q  <= 32'd0;
      bad_q    <= 1'b0;
      rvalid_q <= 1'b0;
      done_q   <= 1'b0;
      err_q    <= 1'b0;
      rdata_q  <= 32'd0;
    end else begin
      state_q  <= state_d;
      cnt_q    <= cnt_d;
      we_q     <= we_d;
      size_q   <= size_d;
      sign_q   <= sign_d;
      addr_q   <= addr_d;
      wdata_q  <= wdata_d;
      bad_q    <= bad_d;
      rvalid_q <= rvalid_d;
      done_q   <= done_d;
      err_q    <= err_d;
      rdata_q  <= rdata_d;
    end
  end

  // Storage is never reset; a write commits the addressed bytes at the end of RESP.
  always_ff @(posedge clk_i) begin
    if (mem_we) begin
      for (int k = 0; k < 4; k++) begin
        if (3'(k) < size_bytes(size_q)) mem[addr_q + AW'(k)] <= wdata_q[8*k +: 8];
      end
    end
  end

endmodule

// File: doc/data_memory_ctrl.md
DATA_MEMORY_CTRL -- requirements
Module: data_memory_ctrl

Interface
REQ-001 The module SHALL have parameter DEPTH_BYTES, default 1024, meaning memory size in bytes (power of two, at least 4).
REQ-002 The module SHALL have parameter LATENCY, default 2, meaning the number of cycles from request accept to response (at least 1).
REQ-003 The module SHALL have one clock and an asynchronous, active-high reset, with ports as listed below.
REQ-004 clk_i  input  1  clock; all state changes on the rising edge.
REQ-005 rst_i  input  1  asynchronous active-high reset.
REQ-006 req_i  input  1  request valid.
REQ-007 we_i  input  1  1 = write, 0 = read.
REQ-008 size_i  input  2  access size: 00 = byte, 01 = half-word, 10 = word, 11 = illegal.
REQ-009 sign_i  input  1  sign-extend read data on byte and half-word reads.
REQ-010 addr_i  input  32  byte address.
REQ-011 wdata_i  input  32  write data, taken from the low bytes.
REQ-012 ready_o  output  1  controller can accept a request.
REQ-013 rvalid_o  output  1  one-cycle pulse: read data valid.
REQ-014 done_o  output  1  one-cycle pulse: write committed.
REQ-015 err_o  output  1  one-cycle pulse: request rejected.
REQ-016 rdata_o  output  32  read data.

Function
REQ-017 Storage SHALL be a DEPTH_BYTES x 8-bit array, little-endian; byte addr+k holds bits [8k+7:8k].
REQ-018 A request SHALL be accepted in cycle T when req_i=1 and ready_o=1; we_i, size_i, sign_i, addr_i and wdata_i SHALL be registered at T.
REQ-019 req_i while ready_o=0 SHALL be ignored; it SHALL NOT be queued.
REQ-020 The FSM SHALL have states IDLE, WAIT and RESP; ready_o SHALL equal 1 only in IDLE.
REQ-021 State transitions SHALL be: IDLE->WAIT on accept when LATENCY>1; IDLE->RESP on accept when LATENCY=1; WAIT->RESP when the latency counter expires; RESP->IDLE unconditionally.
REQ-022 The latency counter SHALL load LATENCY-2 on accept and count down in WAIT; WAIT SHALL last exactly LATENCY-1 cycles.
REQ-023 The response (rvalid_o, done_o or err_o) SHALL be asserted for exactly the one cycle at T+LATENCY, while in RESP.
REQ-024 At most one of rvalid_o, done_o and err_o SHALL be high in any cycle.
REQ-025 ready_o SHALL return to 1 at T+LATENCY+1, giving a maximum throughput of one request per LATENCY+1 cycles.
REQ-026 A request is an error if any of the following holds:
- size_i = 11;
- half-word access with addr[0] = 1;
- word access with addr[1:0] != 0;
- addr + size_bytes - 1 >= DEPTH_BYTES (compared with full 32-bit address, no wrap-around).
REQ-027 An error request SHALL pulse err_o at T+LATENCY, leave memory unchanged, and drive rdata_o to 0.
REQ-028 A valid write SHALL update only the addressed 1, 2 or 4 bytes, at the RESP edge (T+LATENCY), and pulse done_o.
REQ-029 A valid read SHALL sample memory in RESP, so that a write completed earlier is visible, and drive rdata_o as follows:
- byte and half-word reads zero-extend when sign_i=0;
- byte and half-word reads sign-extend from bit 7 or bit 15 when sign_i=1.
REQ-030 rdata_o SHALL be 0 in every cycle where rvalid_o=0.
REQ-031 Memory contents SHALL NOT be initialised by reset; unwritten bytes read as X in simulation.

Reset
REQ-032 While rst_i=1, outputs SHALL be: ready_o=0, rvalid_o=0, done_o=0, err_o=0, rdata_o=0.
REQ-033 While rst_i=1, the state SHALL be IDLE and the counter SHALL be 0.
REQ-034 ready_o SHALL be 1 in the first cycle after rst_i deasserts.
REQ-035 Reset asserted during WAIT or RESP SHALL drop the pending request: no write commit and no response pulse.

Verification
REQ-036 LATENCY=2: word write 0xDEADBEEF at 0x10 accepted at T -> done_o=1 at T+2 and ready_o=1 at T+3; word read at 0x10 -> rvalid_o with rdata_o=0xDEADBEEF two cycles after accept.
REQ-037 Byte read at 0x13 with sign_i=1 -> 0xFFFFFFDE; with sign_i=0 -> 0x000000DE; half-word read at 0x12 with sign_i=1 -> 0xFFFFDEAD.
REQ-038 Half-word write 0x1234 at 0x11 -> err_o pulse, word read at 0x10 still 0xDEADBEEF.
REQ-039 Word read at 0x3FE or at 0x400 (DEPTH_BYTES=1024), and size_i=11 -> err_o pulse and rdata_o=0.
REQ-040 req_i held high for 10 cycles with LATENCY=3 -> exactly 3 accepts, spaced 4 cycles apart.
REQ-041 rst_i asserted during WAIT of word write 0xCAFEF00D at 0x20 (previously holding 0x11111111) -> no done_o pulse, and a read at 0x20 returns 0x11111111.
